// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - instruction/status inputs and datapath strobes of the control unit
interface control_unit_if;
  logic [31:0] instr;
  logic        con;
  logic        stop;
  logic        run;
  logic        PCout, PCin, IncPC, MARin, MDRin, MDRread, MDRout, IRin, Yin, Zlowin, Zhighin;
  logic        ZLowout, ZHighout, HIin, HIout, LOin, LOout, Cout, InPortout, IPin, OPin;
  logic        conffin, wren;
  logic        Gra, Grb, Grc, Rin, Rout, BAout;
  logic [3:0]  ALUselect;

  modport master (
    output instr, con, stop,
    input  run,
    input  PCout, PCin, IncPC, MARin, MDRin, MDRread, MDRout, IRin, Yin, Zlowin, Zhighin,
    input  ZLowout, ZHighout, HIin, HIout, LOin, LOout, Cout, InPortout, IPin, OPin,
    input  conffin, wren, Gra, Grb, Grc, Rin, Rout, BAout, ALUselect
  );

  modport slave (
    input  instr, con, stop,
    output run,
    output PCout, PCin, IncPC, MARin, MDRin, MDRread, MDRout, IRin, Yin, Zlowin, Zhighin,
    output ZLowout, ZHighout, HIin, HIout, LOin, LOout, Cout, InPortout, IPin, OPin,
    output conffin, wren, Gra, Grb, Grc, Rin, Rout, BAout, ALUselect
  );
endinterface

// File: rtl/control_unit.sv
// rtl/control_unit.sv - Moore step-counter control unit with memory-wait and halt states
module control_unit #(
  parameter int MEM_WAIT = 1,
  parameter int OP_W     = 5
) (
  input  logic          clk,
  input  logic          clr,
  control_unit_if.slave cu
);
  typedef enum logic [3:0] {
    S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_WAIT, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_NOP, C_RFMT, C_IMM, C_LD, C_LDI, C_ST, C_MULDIV, C_NEGNOT,
    C_BR, C_JR, C_JAL, C_IN, C_OUT, C_MFLO, C_MFHI, C_HALT
  } cls_t;

  localparam logic [1:0] WAIT_INIT = (MEM_WAIT > 0) ? 2'(MEM_WAIT - 1) : 2'd0;

  function automatic cls_t classify(input logic [OP_W-1:0] op);
    int unsigned v;
    v = 32'(op);
    case (v) inside
      0:       return C_LD;
      1:       return C_LDI;
      2:       return C_ST;
      [3:11]:  return C_RFMT;
      [12:14]: return C_IMM;
      15, 16:  return C_MULDIV;
      17, 18:  return C_NEGNOT;
      19:      return C_BR;
      20:      return C_JAL;
      21:      return C_JR;
      22:      return C_IN;
      23:      return C_OUT;
      24:      return C_MFLO;
      25:      return C_MFHI;
      27:      return C_HALT;
      default: return C_NOP;
    endcase
  endfunction

  function automatic logic [3:0] alu_code(input logic [OP_W-1:0] op);
    int unsigned v;
    v = 32'(op);
    case (v)
      4:       return 4'b0001;
      5, 13:   return 4'b0010;
      6, 14:   return 4'b0011;
      7:       return 4'b0111;
      8:       return 4'b1000;
      9:       return 4'b0100;
      10:      return 4'b0101;
      11:      return 4'b0110;
      15:      return 4'b1100;
      16:      return 4'b1011;
      17:      return 4'b1001;
      18:      return 4'b1010;
      default: return 4'b0000;
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [OP_W-1:0] opcode_q, opcode_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            wait_ld_q, wait_ld_d;
  logic            stop_q, stop_d;
  logic            done;
  cls_t            cls_in, cls_q;
  logic [3:0]      alu;

  assign cls_in = classify(cu.instr[31:32-OP_W]);
  assign cls_q  = classify(opcode_q);
  assign alu    = alu_code(opcode_q);
  assign cu.run = (state_q != S_HALT);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= S_T0;
      opcode_q  <= '0;
      cnt_q     <= 2'd0;
      wait_ld_q <= 1'b0;
      stop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      cnt_q     <= cnt_d;
      wait_ld_q <= wait_ld_d;
      stop_q    <= stop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    cnt_d     = cnt_q;
    wait_ld_d = wait_ld_q;
    done      = 1'b0;
    case (state_q)
      S_T0: begin
        wait_ld_d = 1'b0;
        cnt_d     = WAIT_INIT;
        state_d   = (MEM_WAIT > 0) ? S_WAIT : S_T1;
      end
      S_WAIT: begin
        // the same wait state serves the fetch read and the ld data read
        if (cnt_q == 2'd0) state_d = wait_ld_q ? S_T6 : S_T1;
        else               cnt_d   = cnt_q - 2'd1;
      end
      S_T1: state_d = S_T2;
      S_T2: begin
        opcode_d = cu.instr[31:32-OP_W];
        case (cls_in)
          C_HALT:  state_d = S_HALT;
          C_NOP:   done    = 1'b1;
          default: state_d = S_T3;
        endcase
      end
      S_T3: begin
        if (cls_q inside {C_JR, C_IN, C_OUT, C_MFLO, C_MFHI}) done = 1'b1;
        else state_d = S_T4;
      end
      S_T4: begin
        if (cls_q inside {C_NEGNOT, C_JAL}) done = 1'b1;
        else state_d = S_T5;
      end
      S_T5: begin
        case (cls_q)
          C_RFMT, C_IMM, C_LDI: done = 1'b1;
          C_LD: begin
            if (MEM_WAIT > 0) begin
              state_d   = S_WAIT;
              wait_ld_d = 1'b1;
              cnt_d     = WAIT_INIT;
            end else begin
              state_d = S_T6;
            end
          end
          default: state_d = S_T6;
        endcase
      end
      S_T6: begin
        if (cls_q inside {C_LD, C_ST}) state_d = S_T7;
        else done = 1'b1;
      end
      S_T7:    done = 1'b1;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_T0;
    endcase
    if (done) state_d = (stop_q || cu.stop) ? S_HALT : S_T0;
    stop_d = (state_d == S_T0) ? 1'b0 : (stop_q | cu.stop);
  end

  // strobes are gated by clr so a reset mid-instruction never leaks a write
  always_comb begin
    {cu.PCout, cu.PCin, cu.IncPC, cu.MARin, cu.MDRin, cu.MDRread, cu.MDRout, cu.IRin} = '0;
    {cu.Yin, cu.Zlowin, cu.Zhighin, cu.ZLowout, cu.ZHighout, cu.HIin, cu.HIout} = '0;
    {cu.LOin, cu.LOout, cu.Cout, cu.InPortout, cu.IPin, cu.OPin, cu.conffin, cu.wren} = '0;
    {cu.Gra, cu.Grb, cu.Grc, cu.Rin, cu.Rout, cu.BAout} = '0;
    cu.ALUselect = 4'b0000;
    if (clr) begin
      case (state_q)
        S_T0:   {cu.PCout, cu.MARin, cu.IncPC, cu.IPin} = 4'hF;
        S_WAIT: cu.MDRread = 1'b1;
        S_T1:   {cu.MDRread, cu.MDRin} = 2'b11;
        S_T2:   {cu.MDRout, cu.IRin} = 2'b11;
        S_T3: begin
          case (cls_q)
            C_RFMT, C_IMM:      {cu.Grb, cu.Rout, cu.Yin} = 3'b111;
            C_LD, C_LDI, C_ST:  {cu.Grb, cu.BAout, cu.Yin} = 3'b111;
            C_MULDIV:           {cu.Gra, cu.Rout, cu.Yin} = 3'b111;
            C_NEGNOT: begin
              {cu.Grb, cu.Rout, cu.Zlowin} = 3'b111;
              cu.ALUselect = alu;
            end
            C_BR:    {cu.Gra, cu.Rout, cu.conffin} = 3'b111;
            C_JR:    {cu.Gra, cu.Rout, cu.PCin} = 3'b111;
            C_JAL:   {cu.PCout, cu.Grb, cu.Rin} = 3'b111;
            C_IN:    {cu.InPortout, cu.Gra, cu.Rin} = 3'b111;
            C_OUT:   {cu.Gra, cu.Rout, cu.OPin} = 3'b111;
            C_MFLO:  {cu.LOout, cu.Gra, cu.Rin} = 3'b111;
            C_MFHI:  {cu.HIout, cu.Gra, cu.Rin} = 3'b111;
            default: ;
          endcase
        end
        S_T4: begin
          case (cls_q)
            C_RFMT: begin
              {cu.Grc, cu.Rout, cu.Zlowin} = 3'b111;
              cu.ALUselect = alu;
            end
            C_IMM: begin
              {cu.Cout, cu.Zlowin} = 2'b11;
              cu.ALUselect = alu;
            end
            C_LD, C_LDI, C_ST: {cu.Cout, cu.Zlowin} = 2'b11;
            C_MULDIV: begin
              {cu.Grb, cu.Rout, cu.Zlowin, cu.Zhighin} = 4'hF;
              cu.ALUselect = alu;
            end
            C_NEGNOT: {cu.ZLowout, cu.Gra, cu.Rin} = 3'b111;
            C_BR:     {cu.PCout, cu.Yin} = 2'b11;
            C_JAL:    {cu.Gra, cu.Rout, cu.PCin} = 3'b111;
            default:  ;
          endcase
        end
        S_T5: begin
          case (cls_q)
            C_RFMT, C_IMM, C_LDI: {cu.ZLowout, cu.Gra, cu.Rin} = 3'b111;
            C_LD, C_ST:           {cu.ZLowout, cu.MARin} = 2'b11;
            C_MULDIV:             {cu.ZLowout, cu.LOin} = 2'b11;
            C_BR:                 {cu.Cout, cu.Zlowin} = 2'b11;
            default:              ;
          endcase
        end
        S_T6: begin
          case (cls_q)
            C_LD:     {cu.MDRread, cu.MDRin} = 2'b11;
            C_ST:     {cu.Gra, cu.Rout, cu.MDRin} = 3'b111;
            C_MULDIV: {cu.ZHighout, cu.HIin} = 2'b11;
            C_BR: begin
              cu.ZLowout = 1'b1;
              cu.PCin    = cu.con;
            end
            default:  ;
          endcase
        end
        S_T7: begin
          case (cls_q)
            C_LD:    {cu.MDRout, cu.Gra, cu.Rin} = 3'b111;
            C_ST:    cu.wren = 1'b1;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed bench with a per-instruction step-sequence model of the control unit
module tb_control_unit;
  localparam int MW = 1;

  localparam logic [28:0] PCOUT = 29'd1 << 0, PCIN = 29'd1 << 1, INCPC = 29'd1 << 2, MARIN = 29'd1 << 3;
  localparam logic [28:0] MDRIN = 29'd1 << 4, MDRREAD = 29'd1 << 5, MDROUT = 29'd1 << 6, IRIN = 29'd1 << 7;
  localparam logic [28:0] YIN = 29'd1 << 8, ZLOWIN = 29'd1 << 9, ZHIGHIN = 29'd1 << 10, ZLOWOUT = 29'd1 << 11;
  localparam logic [28:0] ZHIGHOUT = 29'd1 << 12, HIIN = 29'd1 << 13, HIOUT = 29'd1 << 14, LOIN = 29'd1 << 15;
  localparam logic [28:0] LOOUT = 29'd1 << 16, COUT = 29'd1 << 17, INPORTOUT = 29'd1 << 18, IPIN = 29'd1 << 19;
  localparam logic [28:0] OPIN = 29'd1 << 20, CONFFIN = 29'd1 << 21, WREN = 29'd1 << 22, GRA = 29'd1 << 23;
  localparam logic [28:0] GRB = 29'd1 << 24, GRC = 29'd1 << 25, RIN = 29'd1 << 26, ROUT = 29'd1 << 27;
  localparam logic [28:0] BAOUT = 29'd1 << 28;
  localparam logic [28:0] BUS_MASK = PCOUT | MDROUT | ZLOWOUT | ZHIGHOUT | HIOUT | LOOUT | COUT
                                   | INPORTOUT | ROUT | BAOUT;

  typedef struct packed {
    logic [28:0] m;
    logic [3:0]  alu;
    logic        run;
  } exp_t;

  logic clk = 1'b0;
  logic clr = 1'b0;
  control_unit_if cu_if ();

  control_unit #(.MEM_WAIT(MW), .OP_W(5)) dut (
    .clk (clk),
    .clr (clr),
    .cu  (cu_if)
  );

  always #5 clk = ~clk;

  logic [28:0] vec;
  assign vec = {cu_if.BAout, cu_if.Rout, cu_if.Rin, cu_if.Grc, cu_if.Grb, cu_if.Gra, cu_if.wren,
                cu_if.conffin, cu_if.OPin, cu_if.IPin, cu_if.InPortout, cu_if.Cout, cu_if.LOout,
                cu_if.LOin, cu_if.HIout, cu_if.HIin, cu_if.ZHighout, cu_if.ZLowout, cu_if.Zhighin,
                cu_if.Zlowin, cu_if.Yin, cu_if.IRin, cu_if.MDRout, cu_if.MDRread, cu_if.MDRin,
                cu_if.MARin, cu_if.IncPC, cu_if.PCin, cu_if.PCout};

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   wren_cnt = 0;
  int   pcin_cnt = 0;
  int   mdrrd_cnt = 0;
  bit   lohi_seen = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    total++;
    if ($countones(vec & BUS_MASK) > 1) begin
      bad++;
      $display("FAIL bus_single t=%0t got drivers=%h want at most one", $time, vec & BUS_MASK);
    end
    if (vec & WREN) wren_cnt++;
    if (vec & PCIN) pcin_cnt++;
    if (vec & MDRREAD) mdrrd_cnt++;
    if (vec & (LOIN | HIIN)) lohi_seen = 1'b1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (vec !== e.m || cu_if.ALUselect !== e.alu || cu_if.run !== e.run) begin
        bad++;
        $display("FAIL step t=%0t got m=%h alu=%h run=%b want m=%h alu=%h run=%b",
                 $time, vec, cu_if.ALUselect, cu_if.run, e.m, e.alu, e.run);
      end
    end
  end

  function automatic logic [3:0] alu_of(input logic [4:0] op);
    case (op)
      5'd3, 5'd12: return 4'b0000;
      5'd4:        return 4'b0001;
      5'd5, 5'd13: return 4'b0010;
      5'd6, 5'd14: return 4'b0011;
      5'd9:        return 4'b0100;
      5'd10:       return 4'b0101;
      5'd11:       return 4'b0110;
      5'd7:        return 4'b0111;
      5'd8:        return 4'b1000;
      5'd17:       return 4'b1001;
      5'd18:       return 4'b1010;
      5'd16:       return 4'b1011;
      5'd15:       return 4'b1100;
      default:     return 4'b0000;
    endcase
  endfunction

  task automatic push(input logic [28:0] m, input logic [3:0] a);
    exp_q.push_back({m, a, 1'b1});
  endtask

  task automatic push_halt(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({29'd0, 4'd0, 1'b0});
  endtask

  task automatic push_fetch();
    push(PCOUT | MARIN | INCPC | IPIN, 4'd0);
    for (int i = 0; i < MW; i++) push(MDRREAD, 4'd0);
    push(MDRREAD | MDRIN, 4'd0);
    push(MDROUT | IRIN, 4'd0);
  endtask

  task automatic push_exec(input logic [4:0] op, input logic c);
    logic [3:0] a;
    a = alu_of(op);
    case (op) inside
      [5'd3:5'd11]: begin
        push(GRB | ROUT | YIN, 4'd0); push(GRC | ROUT | ZLOWIN, a); push(ZLOWOUT | GRA | RIN, 4'd0);
      end
      [5'd12:5'd14]: begin
        push(GRB | ROUT | YIN, 4'd0); push(COUT | ZLOWIN, a); push(ZLOWOUT | GRA | RIN, 4'd0);
      end
      5'd0, 5'd1, 5'd2: begin
        push(GRB | BAOUT | YIN, 4'd0);
        push(COUT | ZLOWIN, 4'd0);
        push((op == 5'd1) ? (ZLOWOUT | GRA | RIN) : (ZLOWOUT | MARIN), 4'd0);
        if (op == 5'd0) begin
          for (int i = 0; i < MW; i++) push(MDRREAD, 4'd0);
          push(MDRREAD | MDRIN, 4'd0);
          push(MDROUT | GRA | RIN, 4'd0);
        end
        if (op == 5'd2) begin
          push(GRA | ROUT | MDRIN, 4'd0);
          push(WREN, 4'd0);
        end
      end
      5'd15, 5'd16: begin
        push(GRA | ROUT | YIN, 4'd0); push(GRB | ROUT | ZLOWIN | ZHIGHIN, a);
        push(ZLOWOUT | LOIN, 4'd0);   push(ZHIGHOUT | HIIN, 4'd0);
      end
      5'd17, 5'd18: begin
        push(GRB | ROUT | ZLOWIN, a); push(ZLOWOUT | GRA | RIN, 4'd0);
      end
      5'd19: begin
        push(GRA | ROUT | CONFFIN, 4'd0); push(PCOUT | YIN, 4'd0);
        push(COUT | ZLOWIN, 4'd0);        push(ZLOWOUT | (c ? PCIN : 29'd0), 4'd0);
      end
      5'd20: begin
        push(PCOUT | GRB | RIN, 4'd0); push(GRA | ROUT | PCIN, 4'd0);
      end
      5'd21: push(GRA | ROUT | PCIN, 4'd0);
      5'd22: push(INPORTOUT | GRA | RIN, 4'd0);
      5'd23: push(GRA | ROUT | OPIN, 4'd0);
      5'd24: push(LOOUT | GRA | RIN, 4'd0);
      5'd25: push(HIOUT | GRA | RIN, 4'd0);
      default: ;
    endcase
  endtask

  // returns at posedge+1 once every queued step has been compared
  task automatic drain();
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      cu_if.stop = 1'b0;
      if (exp_q.size() == 0) break;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout got left=%0d want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_instr(input logic [31:0] ins, input logic c, input logic st);
    logic [4:0] op;
    op = ins[31:27];
    cu_if.instr = ins;
    cu_if.con   = c;
    cu_if.stop  = st;
    push_fetch();
    if (op == 5'd27) push_halt(100);
    else push_exec(op, c);
    if (st && op != 5'd27) push_halt(20);
    drain();
  endtask

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic reset_pulse(input int cycles);
    clr = 1'b0;
    #1;
    check("reset_strobes", int'(vec), 0);
    check("reset_alu", int'(cu_if.ALUselect), 0);
    check("reset_run", int'(cu_if.run), 1);
    repeat (cycles) @(posedge clk);
    #1;
    check("reset_hold_strobes", int'(vec), 0);
    clr = 1'b1;
  endtask

  logic [4:0] ops [19] = '{5'd4, 5'd9, 5'd7, 5'd8, 5'd5, 5'd6, 5'd10, 5'd11, 5'd12, 5'd13,
                           5'd14, 5'd1, 5'd16, 5'd15, 5'd17, 5'd18, 5'd22, 5'd23, 5'd31};

  initial begin
    cu_if.instr = 32'h0;
    cu_if.con   = 1'b0;
    cu_if.stop  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_pulse(2);

    do_instr(32'h1989_0000, 1'b0, 1'b0);
    for (int i = 0; i < 19; i++) do_instr({ops[i], 27'h0}, 1'b0, 1'b0);

    mdrrd_cnt = 0;
    do_instr({5'd26, 27'h0}, 1'b0, 1'b0);
    check("nop_mdrread_cycles", mdrrd_cnt, 2);
    mdrrd_cnt = 0;
    do_instr({5'd0, 27'h0}, 1'b0, 1'b0);
    check("ld_mdrread_cycles", mdrrd_cnt, 4);
    wren_cnt = 0;
    do_instr({5'd2, 27'h0}, 1'b0, 1'b0);
    check("st_wren_cycles", wren_cnt, 1);
    pcin_cnt = 0;
    do_instr({5'd19, 27'h0}, 1'b0, 1'b0);
    check("br_con0_pcin", pcin_cnt, 0);
    pcin_cnt = 0;
    do_instr({5'd19, 27'h0}, 1'b1, 1'b0);
    check("br_con1_pcin", pcin_cnt, 1);
    pcin_cnt = 0;
    do_instr({5'd21, 27'h0}, 1'b0, 1'b0);
    do_instr({5'd20, 27'h0}, 1'b0, 1'b0);
    do_instr({5'd24, 27'h0}, 1'b0, 1'b0);
    do_instr({5'd25, 27'h0}, 1'b0, 1'b0);
    check("jr_jal_pcin", pcin_cnt, 2);

    do_instr(32'h1989_0000, 1'b0, 1'b1);
    check("stop_run_low", int'(cu_if.run), 0);
    reset_pulse(2);
    do_instr({5'd3, 27'h0}, 1'b0, 1'b0);

    lohi_seen = 1'b0;
    cu_if.instr = {5'd16, 27'h0};
    push_fetch();
    push(GRA | ROUT | YIN, 4'd0);
    drain();
    reset_pulse(3);
    do_instr({5'd26, 27'h0}, 1'b0, 1'b0);
    check("abort_lohi", int'(lohi_seen), 0);

    do_instr(32'hD800_0000, 1'b0, 1'b0);
    check("halt_run_low", int'(cu_if.run), 0);
    check("halt_strobes", int'(vec), 0);
    reset_pulse(2);
    do_instr(32'h1989_0000, 1'b0, 1'b0);
    check("resume_run", int'(cu_if.run), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter MEM_WAIT, default 1, number of idle cycles between MARin and MDRin on a memory read (0-3).
REQ-002 Parameter OP_W, default 5, opcode width, fixed at instr[31:27].
REQ-003 clk  in  1  system clock; all state changes on the rising edge.
REQ-004 clr  in  1  asynchronous, active-low reset.
REQ-005 instr  in  32  IR contents; opcode is instr[31:27].
REQ-006 con  in  1  CON_FF result (conffout of datapath).
REQ-007 stop  in  1  request to halt after the current instruction.
REQ-008 run  out  1  high while not halted.
REQ-009 PCout, PCin, IncPC, MARin, MDRin, MDRread, MDRout, IRin, Yin, Zlowin, Zhighin, ZLowout, ZHighout, HIin, HIout, LOin, LOout, Cout, InPortout, IPin, OPin, conffin, wren  out  1 each  datapath strobes.
REQ-010 Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  select/encode controls.
REQ-011 ALUselect  out  4  ALU operation.

Function
REQ-012 Moore FSM: states T0..T7 (step counter) plus WAIT (memory latency) and HALT; outputs are decoded from state and the latched opcode only; unlisted outputs are 0 in every state.
REQ-013 ALUselect codes: ADD 0000, SUB 0001, AND 0010, OR 0011, SHR 0100, SHRA 0101, SHL 0110, ROR 0111, ROL 1000, NEG 1001, NOT 1010, MUL 1011, DIV 1100.
REQ-014 Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011, addi 01100, andi 01101, ori 01110, div 01111, mul 10000, neg 10001, not 10010, br 10011, jal 10100, jr 10101, in 10110, out 10111, mflo 11000, mfhi 11001, nop 11010, halt 11011; any other opcode executes as nop.
REQ-015 Fetch: T0 PCout MARin IncPC IPin; WAIT xMEM_WAIT with MDRread; T1 MDRread MDRin; T2 MDRout IRin; opcode decoded from instr from T3 on.
REQ-016 R-format ALU (add..shl): T3 Grb Rout Yin; T4 Grc Rout ALUselect Zlowin; T5 ZLowout Gra Rin.
REQ-017 Immediate (addi/andi/ori): T3 Grb Rout Yin; T4 Cout ALUselect Zlowin; T5 ZLowout Gra Rin.
REQ-018 ld/ldi/st address: T3 Grb BAout Yin; T4 Cout ADD Zlowin; ldi T5 ZLowout Gra Rin; ld/st T5 ZLowout MARin.
REQ-019 ld: WAIT xMEM_WAIT with MDRread; T6 MDRread MDRin; T7 MDRout Gra Rin.
REQ-020 st: T6 Gra Rout MDRin (MDRread=0); T7 wren.
REQ-021 mul/div: T3 Gra Rout Yin; T4 Grb Rout ALUselect Zlowin Zhighin; T5 ZLowout LOin; T6 ZHighout HIin.
REQ-022 neg/not: T3 Grb Rout ALUselect Zlowin; T4 ZLowout Gra Rin.
REQ-023 br: T3 Gra Rout conffin; T4 PCout Yin; T5 Cout ADD Zlowin; T6 ZLowout, plus PCin only if con=1 in T6.
REQ-024 jr: T3 Gra Rout PCin; jal: T3 PCout Grb Rin, T4 Gra Rout PCin.
REQ-025 in: T3 InPortout Gra Rin; out: T3 Gra Rout OPin; mflo: T3 LOout Gra Rin; mfhi: T3 HIout Gra Rin; nop: no T3.
REQ-026 After an instruction's last step the next cycle is T0, or HALT if stop was sampled high during any step of that instruction.
REQ-027 halt opcode enters HALT the cycle after T2; HALT is absorbing until reset; run=0 in HALT, 1 otherwise.
REQ-028 At most one bus-driver output (PCout, MDRout, ZLowout, ZHighout, HIout, LOout, Cout, InPortout, Rout, BAout) is high in any cycle.

Reset
REQ-029 clr low forces state T0 and all strobes 0 immediately, regardless of clk, including mid-instruction (no partial register write or wren).
REQ-030 First rising edge after clr returns high completes T0; run=1 throughout reset and after.

Verification
REQ-031 Reset, MEM_WAIT=1 -> T0 asserts PCout MARin IncPC IPin; one WAIT cycle with MDRread only; T1 MDRread MDRin; T2 MDRout IRin.
REQ-032 instr=0x19890000 (add r3,r1,r2) -> T3 Grb Rout Yin; T4 Grc Rout Zlowin ALUselect=0000; T5 ZLowout Gra Rin; next cycle T0.
REQ-033 br with con=0 in T6 -> PCin never asserted, T0 follows; repeat with con=1 -> PCin high in T6 only.
REQ-034 st -> wren high for exactly one cycle (T7), MDRread low in T6.
REQ-035 instr=0xD8000000 (halt) -> run falls after T2, outputs stay 0 for 100 cycles; clr low then high -> T0 resumes.
REQ-036 clr pulsed low during T4 of mul -> LOin/HIin never asserted, fetch restarts at T0; checker asserts REQ-028 in every cycle.
